// File: rtl/ahb_dw64to32_bridge_if.sv
// AHB-lite bus bundle shared by the 64-bit upstream and 32-bit downstream
// sides of the width bridge. DW selects the data width of each instance.
// The HRESP signal exists only when AHB_BRIDGE_HRESP_EN is defined.
interface ahb_dw64to32_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
`ifdef AHB_BRIDGE_HRESP_EN
    logic          HRESP;

    modport master (output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                    input  HRDATA, HREADY, HRESP);
    modport slave  (input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                    output HRDATA, HREADY, HRESP);
`else
    modport master (output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                    input  HRDATA, HREADY);
    modport slave  (input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                    output HRDATA, HREADY);
`endif
endinterface

// File: rtl/ahb_dw64to32_bridge.sv
// 64-bit to 32-bit AHB-lite width bridge. A doubleword access becomes a
// NONSEQ+SEQ pair of word beats; narrower accesses pass through as one beat.
// Optional AHB_BRIDGE_HRESP_EN adds two-cycle error response forwarding.
module ahb_dw64to32_bridge #(
    parameter int AW = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ahb_dw64to32_bridge_if.slave   up,
    ahb_dw64to32_bridge_if.master  dn
);
    typedef enum logic [1:0] {IDLE, A1, D1, D2} state_e;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] SZ_WORD   = 3'b010;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          write_q, write_d;
    logic          is64_q, is64_d;
    logic [31:0]   lo_q, lo_d;

    logic [AW-1:0] base, base_hi;
    logic          in_data, err_wait, err_done, accept;

    // Doubleword beats always start on the 8-byte boundary; the second beat
    // is the same boundary with bit 2 set.
    assign base    = {addr_q[AW-1:3], 3'b000};
    assign base_hi = {addr_q[AW-1:3], 3'b100};
    assign in_data = (state_q == D1) || (state_q == D2);

`ifdef AHB_BRIDGE_HRESP_EN
    // First error cycle stalls upstream, second one completes it.
    assign err_wait = in_data & dn.HRESP & ~dn.HREADY;
    assign err_done = in_data & dn.HRESP &  dn.HREADY;
    assign up.HRESP = err_wait | err_done;
`else
    assign err_wait = 1'b0;
    assign err_done = 1'b0;
`endif

    // Next state, downstream beat generation and upstream completion.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        is64_d     = is64_q;
        lo_d       = lo_q;
        accept     = 1'b0;
        up.HREADY  = 1'b0;
        up.HRDATA  = '0;
        dn.HTRANS  = TR_IDLE;
        dn.HADDR   = '0;
        dn.HWRITE  = 1'b0;
        dn.HSIZE   = '0;
        dn.HWDATA  = '0;

        case (state_q)
            IDLE: up.HREADY = 1'b1;
            A1: begin
                dn.HTRANS = TR_NONSEQ;
                dn.HADDR  = is64_q ? base : addr_q;
                dn.HWRITE = write_q;
                dn.HSIZE  = is64_q ? SZ_WORD : size_q;
                if (dn.HREADY) state_d = D1;
            end
            D1: begin
                dn.HWRITE = write_q;
                dn.HSIZE  = is64_q ? SZ_WORD : size_q;
                // A narrow access to the upper word rides on the upper lane.
                dn.HWDATA = (!is64_q && addr_q[2]) ? up.HWDATA[63:32] : up.HWDATA[31:0];
                if (is64_q) begin
                    // Second beat's address phase overlaps the first data phase,
                    // but is withheld once an error is signalled.
                    dn.HTRANS = (err_wait || err_done) ? TR_IDLE : TR_SEQ;
                    dn.HADDR  = base_hi;
                    if (dn.HREADY) begin
                        lo_d    = dn.HRDATA;
                        state_d = D2;
                    end
                end else begin
                    dn.HADDR = addr_q;
                    if (dn.HREADY) begin
                        up.HREADY = 1'b1;
                        up.HRDATA = {dn.HRDATA, dn.HRDATA};
                        state_d   = IDLE;
                    end
                end
            end
            D2: begin
                dn.HADDR  = base_hi;
                dn.HWRITE = write_q;
                dn.HSIZE  = SZ_WORD;
                dn.HWDATA = up.HWDATA[63:32];
                if (dn.HREADY) begin
                    up.HREADY = 1'b1;
                    up.HRDATA = {dn.HRDATA, lo_q};
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An error completion ends the transfer outright; no new accept.
        if (err_done) begin
            up.HREADY = 1'b1;
            up.HRDATA = '0;
            state_d   = IDLE;
        end

        accept = up.HREADY & up.HTRANS[1] & ~err_done;
        if (accept) begin
            state_d = A1;
            addr_d  = up.HADDR;
            size_d  = up.HSIZE;
            write_d = up.HWRITE;
            is64_d  = (up.HSIZE >= 3'd3);
        end
    end

    // State and captured address-phase registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            is64_q  <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            is64_q  <= is64_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_ahb_dw64to32_bridge.sv
// Bench for ahb_dw64to32_bridge: byte-level reference memory predicts read
// data and the downstream beat list; a randomized-wait word slave answers.
module tb_ahb_dw64to32_bridge;
    localparam int AW = 32;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_dw64to32_bridge_if #(.AW(AW), .DW(64)) up();
    ahb_dw64to32_bridge_if #(.AW(AW), .DW(32)) dn();

    ahb_dw64to32_bridge #(.AW(AW)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .up(up), .dn(dn));

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic        gap;
    } op_t;

    int n_vec = 0;
    int n_err = 0;
    int fix_wait = 0;
    logic err_arm = 1'b0;

    beat_t obs_q[$];
    beat_t exp_q[$];
    op_t   op_q[$];
    logic [63:0] exp_rd[$];
    logic [63:0] rd_q[$];
    int    st_q[$];
    int    nz_cnt;

    logic [31:0] ds_mem [int unsigned];
    logic [7:0]  ref_mem [int unsigned];

    function automatic logic [31:0] ds_rd(input logic [31:0] wi);
        return ds_mem.exists(wi) ? ds_mem[wi] : 32'h0;
    endfunction

    function automatic logic [7:0] ref_rd8(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
    endfunction

    // Reference: bytes of the access, expected beats, expected read data.
    function automatic logic [63:0] model(input op_t o);
        beat_t b;
        logic [31:0] bs, w, lane;
        logic [63:0] r;
        r = '0; w = '0;
        if (o.size >= 3) begin
            bs = {o.addr[31:3], 3'b000};
            b.addr = bs; b.trans = 2'b10; b.size = 3'b010; b.write = o.write;
            b.wdata = o.write ? o.wdata[31:0] : 32'h0;
            exp_q.push_back(b);
            b.addr = bs + 32'd4; b.trans = 2'b11;
            b.wdata = o.write ? o.wdata[63:32] : 32'h0;
            exp_q.push_back(b);
            for (int k = 0; k < 8; k++) begin
                if (o.write) ref_mem[bs + 32'(k)] = o.wdata[8*k +: 8];
                else r[8*k +: 8] = ref_rd8(bs + 32'(k));
            end
        end else begin
            lane = o.addr[2] ? o.wdata[63:32] : o.wdata[31:0];
            b.addr = o.addr; b.trans = 2'b10; b.size = o.size; b.write = o.write;
            b.wdata = o.write ? lane : 32'h0;
            exp_q.push_back(b);
            if (o.write) begin
                for (int k = 0; k < (1 << o.size); k++) begin
                    bs = o.addr + 32'(k);
                    ref_mem[bs] = lane[8*bs[1:0] +: 8];
                end
            end else begin
                bs = {o.addr[31:2], 2'b00};
                for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_rd8(bs + 32'(k));
                r = {w, w};
            end
        end
        return o.write ? 64'h0 : r;
    endfunction

    // Downstream word slave with random or fixed wait states.
    logic        dp_v = 1'b0, dp_w, dp_err, r_done, r_acc, r_nw;
    logic [31:0] dp_addr, r_na, r_word;
    logic [1:0]  dp_trans, r_nt;
    logic [2:0]  dp_size, r_ns;
    int          wcnt;
    beat_t       r_b;
    initial begin
        dn.HREADY = 1'b1;
        dn.HRDATA = 32'h0;
`ifdef AHB_BRIDGE_HRESP_EN
        dn.HRESP = 1'b0;
`endif
        forever begin
            @(negedge HCLK);
            r_done = dp_v && dn.HREADY;
            r_acc  = dn.HTRANS[1] && dn.HREADY;
            r_na = dn.HADDR; r_nt = dn.HTRANS; r_ns = dn.HSIZE; r_nw = dn.HWRITE;
            if (r_done) begin
                r_b.addr = dp_addr; r_b.trans = dp_trans; r_b.size = dp_size; r_b.write = dp_w;
                r_b.wdata = dp_w ? dn.HWDATA : 32'h0;
                obs_q.push_back(r_b);
                if (dp_w && !dp_err) begin
                    r_word = ds_rd({2'b00, dp_addr[31:2]});
                    for (int k = 0; k < (1 << dp_size); k++)
                        r_word[8*(dp_addr[1:0]+k) +: 8] = dn.HWDATA[8*(dp_addr[1:0]+k) +: 8];
                    ds_mem[{2'b00, dp_addr[31:2]}] = r_word;
                end
            end
            @(posedge HCLK); #1;
            if (r_acc) begin
                dp_v = 1'b1; dp_addr = r_na; dp_trans = r_nt; dp_size = r_ns; dp_w = r_nw;
                dp_err = err_arm; err_arm = 1'b0;
                wcnt = dp_err ? 1 : (fix_wait >= 0 ? fix_wait : int'($urandom_range(0, 2)));
            end else if (r_done) begin
                dp_v = 1'b0;
            end else if (dp_v && wcnt > 0) begin
                wcnt--;
            end
            dn.HREADY = !dp_v || (wcnt == 0);
            dn.HRDATA = (dp_v && !dp_w && wcnt == 0) ? ds_rd({2'b00, dp_addr[31:2]}) : 32'h0;
`ifdef AHB_BRIDGE_HRESP_EN
            dn.HRESP = dp_v && dp_err;
`endif
        end
    end

    // Pipelined upstream master: next address overlaps current data phase.
    task automatic run_ops();
        int idx = 0;
        int stall = 0;
        int cyc = 0;
        bit hv = 0;
        op_t dp;
        rd_q.delete(); st_q.delete(); nz_cnt = 0;
        @(posedge HCLK); #1;
        while (idx < op_q.size() || hv) begin
            if (idx < op_q.size() && !(hv && op_q[idx].gap)) begin
                up.HTRANS = 2'b10; up.HADDR = op_q[idx].addr;
                up.HWRITE = op_q[idx].write; up.HSIZE = op_q[idx].size;
            end else begin
                up.HTRANS = 2'b00;
            end
            up.HWDATA = hv ? dp.wdata : 64'h0;
            @(negedge HCLK);
            if (up.HREADY) begin
                if (hv) begin rd_q.push_back(up.HRDATA); st_q.push_back(stall); hv = 0; end
                if (up.HTRANS[1]) begin dp = op_q[idx]; idx++; hv = 1; stall = 0; end
            end else begin
                stall++;
                if (up.HRDATA !== 64'h0) nz_cnt++;
            end
            @(posedge HCLK); #1;
            if (++cyc > 1000) begin
                n_vec++; n_err++;
                $display("FAIL run_ops_timeout: got %0d done want %0d", idx, op_q.size());
                break;
            end
        end
        up.HTRANS = 2'b00;
        repeat (2) @(posedge HCLK);
        #1;
    endtask

    task automatic prep();
        op_q.delete(); exp_q.delete(); exp_rd.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        up.HTRANS = 2'b00; up.HADDR = '0; up.HWRITE = 1'b0; up.HSIZE = '0; up.HWDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        n_vec++; if (up.HREADY !== 1'b1) begin n_err++; $display("FAIL reset_hready: got %b want 1", up.HREADY); end
        n_vec++; if (up.HRDATA !== 64'h0) begin n_err++; $display("FAIL reset_hrdata: got %h want 0", up.HRDATA); end
        n_vec++; if ({dn.HTRANS, dn.HWRITE, dn.HSIZE} !== 6'h0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", {dn.HTRANS, dn.HWRITE, dn.HSIZE}); end
        n_vec++; if (dn.HADDR !== 32'h0) begin n_err++; $display("FAIL reset_haddr: got %h want 0", dn.HADDR); end
        n_vec++; if (dn.HWDATA !== 32'h0) begin n_err++; $display("FAIL reset_hwdata: got %h want 0", dn.HWDATA); end
        @(negedge HCLK); HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);
    endtask

    task automatic test_spec_vectors();
        op_t o;
        logic [63:0] pre;
        // Doubleword write, zero-wait slave.
        prep(); fix_wait = 0;
        o = '{addr: 32'h100, write: 1'b1, size: 3'd3, wdata: 64'h1122334455667788, gap: 1'b1};
        op_q.push_back(o); void'(model(o));
        run_ops();
        n_vec++; if (st_q.size() != 1 || st_q[0] != 2) begin n_err++; $display("FAIL dw_write_stall: got %0d want 2", st_q.size() ? st_q[0] : -1); end
        n_vec++; if (obs_q.size() != 2) begin n_err++; $display("FAIL dw_write_beats: got %0d want 2", obs_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL dw_write_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        // Doubleword read with one wait per beat.
        prep(); fix_wait = 1;
        pre = 64'hBBBB0002AAAA0001;
        ds_mem[32'h208 >> 2] = pre[31:0]; ds_mem[32'h20C >> 2] = pre[63:32];
        for (int k = 0; k < 8; k++) ref_mem[32'h208 + 32'(k)] = pre[8*k +: 8];
        o = '{addr: 32'h208, write: 1'b0, size: 3'd3, wdata: 64'h0, gap: 1'b1};
        op_q.push_back(o); void'(model(o));
        run_ops();
        n_vec++; if (rd_q.size() != 1 || rd_q[0] !== 64'hBBBB0002AAAA0001) begin n_err++; $display("FAIL dw_read_data: got %h want bbbb0002aaaa0001", rd_q.size() ? rd_q[0] : 64'hx); end
        // Word write on upper lane, then byte read.
        prep(); fix_wait = 0;
        o = '{addr: 32'h00C, write: 1'b1, size: 3'd2, wdata: 64'hDEADBEEF_00000000, gap: 1'b1};
        op_q.push_back(o); exp_rd.push_back(model(o));
        o = '{addr: 32'h003, write: 1'b0, size: 3'd0, wdata: 64'h0, gap: 1'b1};
        op_q.push_back(o); exp_rd.push_back(model(o));
        run_ops();
        n_vec++; if (obs_q.size() != 2) begin n_err++; $display("FAIL narrow_beats: got %0d want 2", obs_q.size()); end
        else begin
            n_vec++; if (obs_q[0] !== {32'h00C, 2'b10, 3'b010, 1'b1, 32'hDEADBEEF}) begin n_err++; $display("FAIL word_write_beat: got %h want %h", obs_q[0], exp_q[0]); end
            n_vec++; if (obs_q[1] !== {32'h003, 2'b10, 3'b000, 1'b0, 32'h0}) begin n_err++; $display("FAIL byte_read_beat: got %h want %h", obs_q[1], exp_q[1]); end
        end
        n_vec++; if (st_q.size() != 2 || st_q[1] != 1) begin n_err++; $display("FAIL narrow_stall: got %0d want 1", st_q.size() > 1 ? st_q[1] : -1); end
        n_vec++; if (rd_q.size() != 2 || rd_q[1] !== exp_rd[1]) begin n_err++; $display("FAIL byte_read_data: got %h want %h", rd_q.size() > 1 ? rd_q[1] : 64'hx, exp_rd[1]); end
    endtask

    task automatic test_back_to_back();
        op_t o;
        prep(); fix_wait = 0;
        o = '{addr: 32'h0, write: 1'b0, size: 3'd3, wdata: 64'h0, gap: 1'b0};
        op_q.push_back(o); exp_rd.push_back(model(o));
        o.addr = 32'h8;
        op_q.push_back(o); exp_rd.push_back(model(o));
        run_ops();
        n_vec++; if (st_q.size() != 2 || st_q[0] != 2 || st_q[1] != 2) begin n_err++; $display("FAIL b2b_stalls: got %0d entries want 2x2", st_q.size()); end
        n_vec++; if (rd_q.size() != 2 || rd_q[1] !== exp_rd[1]) begin n_err++; $display("FAIL b2b_rdata: got %h want %h", rd_q.size() > 1 ? rd_q[1] : 64'hx, exp_rd[1]); end
        n_vec++; if (obs_q.size() != 4 || obs_q[2] !== exp_q[2]) begin n_err++; $display("FAIL b2b_beats: got %0d beats want 4", obs_q.size()); end
    endtask

    task automatic test_random();
        op_t o;
        for (int rnd = 0; rnd < 2; rnd++) begin
            prep(); fix_wait = (rnd == 0) ? -1 : 0;
            for (int i = 0; i < 30; i++) begin
                o.size  = 3'($urandom_range(0, 3));
                o.write = 1'($urandom_range(0, 1));
                o.addr  = 32'($urandom_range(0, 63)) & ~((32'd1 << o.size) - 32'd1);
                o.wdata = {$urandom, $urandom};
                o.gap   = ($urandom_range(0, 3) == 0);
                op_q.push_back(o); exp_rd.push_back(model(o));
            end
            run_ops();
            n_vec++; if (rd_q.size() != op_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", rd_q.size(), op_q.size()); end
            else for (int i = 0; i < op_q.size(); i++) begin
                if (!op_q[i].write) begin
                    n_vec++; if (rd_q[i] !== exp_rd[i]) begin n_err++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, rd_q[i], exp_rd[i]); end
                end
                if (rnd == 1) begin
                    n_vec++; if (st_q[i] != ((op_q[i].size >= 3) ? 2 : 1)) begin n_err++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, st_q[i], (op_q[i].size >= 3) ? 2 : 1); end
                end
            end
            n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_beat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
            n_vec++; if (nz_cnt != 0) begin n_err++; $display("FAIL rand_hrdata_stall: got %0d nonzero want 0", nz_cnt); end
        end
    endtask

`ifdef AHB_BRIDGE_HRESP_EN
    task automatic test_hresp();
        prep(); fix_wait = 0; err_arm = 1'b1;
        @(posedge HCLK); #1;
        up.HTRANS = 2'b10; up.HADDR = 32'h40; up.HWRITE = 1'b1; up.HSIZE = 3'd3;
        @(posedge HCLK); #1;
        up.HTRANS = 2'b00; up.HWDATA = 64'h0123456789ABCDEF;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        n_vec++; if ({up.HRESP, up.HREADY} !== 2'b10) begin n_err++; $display("FAIL hresp_cycle1: got %b want 10", {up.HRESP, up.HREADY}); end
        @(posedge HCLK); #1;
        @(negedge HCLK);
        n_vec++; if ({up.HRESP, up.HREADY} !== 2'b11) begin n_err++; $display("FAIL hresp_cycle2: got %b want 11", {up.HRESP, up.HREADY}); end
        repeat (4) @(posedge HCLK);
        #1;
        n_vec++; if (obs_q.size() != 1 || obs_q[0].addr !== 32'h40) begin n_err++; $display("FAIL hresp_no_second_beat: got %0d beats want 1", obs_q.size()); end
    endtask
`endif

    task automatic test_reset_mid();
        prep(); fix_wait = 0;
        @(posedge HCLK); #1;
        up.HTRANS = 2'b10; up.HADDR = 32'h18; up.HWRITE = 1'b1; up.HSIZE = 3'd3;
        @(posedge HCLK); #1;
        up.HTRANS = 2'b00; up.HWDATA = {$urandom | 32'h1, $urandom};
        repeat (2) @(posedge HCLK);
        #3;
        n_vec++; if (dn.HADDR !== 32'h1C) begin n_err++; $display("FAIL pre_reset_d2_addr: got %h want 1c", dn.HADDR); end
        HRESETn = 1'b0;
        #1;
        n_vec++; if ({up.HREADY, up.HRDATA} !== {1'b1, 64'h0}) begin n_err++; $display("FAIL mid_reset_up: got %b/%h want 1/0", up.HREADY, up.HRDATA); end
        n_vec++; if ({dn.HTRANS, dn.HWRITE, dn.HSIZE, dn.HADDR, dn.HWDATA} !== 70'h0) begin n_err++; $display("FAIL mid_reset_dn: got %h want 0", {dn.HTRANS, dn.HWRITE, dn.HSIZE, dn.HADDR, dn.HWDATA}); end
        @(negedge HCLK); HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_random();
`ifdef AHB_BRIDGE_HRESP_EN
        test_hresp();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
